// File: rtl/rbcp_bus_arbiter_if.sv
// RBCP host-side and slave-side bus signals of the RBCP bus arbiter.
// master = the arbiter's view; slave = the view of the RBCP host and the slaves that drive it.
interface rbcp_bus_arbiter_if #(
  parameter int N_SLAVES = 5
);
  logic                    RBCP_ACT;
  logic [31:0]             RBCP_ADDR;
  logic                    RBCP_WE;
  logic                    RBCP_RE;
  logic [7:0]              RBCP_WD;
  logic [7:0]              RBCP_RD;
  logic                    RBCP_ACK;
  logic [N_SLAVES-1:0]     S_SEL;
  logic [15:0]             S_ADDR;
  logic                    S_WE;
  logic                    S_RE;
  logic [7:0]              S_WD;
  logic [N_SLAVES*8-1:0]   S_RD;
  logic [N_SLAVES-1:0]     S_ACK;

  modport master (
    input  RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_RE, RBCP_WD,
    output RBCP_RD, RBCP_ACK,
    output S_SEL, S_ADDR, S_WE, S_RE, S_WD,
    input  S_RD, S_ACK
  );

  modport slave (
    output RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_RE, RBCP_WD,
    input  RBCP_RD, RBCP_ACK,
    input  S_SEL, S_ADDR, S_WE, S_RE, S_WD,
    output S_RD, S_ACK
  );
endinterface

// File: rtl/rbcp_bus_arbiter.sv
// Decodes RBCP accesses onto one of N_SLAVES regions, holds the slave strobe until the
// slave acks or the wait limit expires, and counts unmapped and timed-out accesses.
module rbcp_bus_arbiter #(
  parameter int                      N_SLAVES    = 5,
  parameter logic [N_SLAVES*16-1:0]  REGION_BASE = {16'h4, 16'h3, 16'h2, 16'h1, 16'h0},
  parameter int                      TIMEOUT     = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  rbcp_bus_arbiter_if.master   bus,
  input  logic                 CNT_CLR,
  output logic [7:0]           CNT_TIMEOUT,
  output logic [7:0]           CNT_UNMAPPED,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Last wait-counter value before giving up: ISSUE plus TIMEOUT WAIT cycles of strobe.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t              state;
  logic [15:0]         wait_cnt;
  logic                req;
  logic [N_SLAVES-1:0] hit_sel;
  logic                hit;
  logic                ack_sel;
  logic [7:0]          sel_rd;
  logic                timed_out;
  logic                unmapped;

  assign req = bus.RBCP_WE | bus.RBCP_RE;

  // Walk downwards so the lowest matching region overwrites any higher one.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    hit_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (bus.RBCP_ADDR[31:16] == REGION_BASE[i*16 +: 16]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  assign hit = |hit_sel;

  // S_SEL is one-hot while a slave is strobed, so it masks out foreign acks and data.
  assign ack_sel = |(bus.S_ACK & bus.S_SEL);

  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (bus.S_SEL[i]) sel_rd |= bus.S_RD[i*8 +: 8];
    end
  end

  assign timed_out = (state == WAIT) && bus.RBCP_ACT && !ack_sel && (wait_cnt == WAIT_LAST);
  assign unmapped  = (state == IDLE) && req && !hit;
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (RST) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bus.RBCP_ACK <= 1'b0;
      bus.RBCP_RD  <= '0;
      bus.S_SEL    <= '0;
      bus.S_WE     <= 1'b0;
      bus.S_RE     <= 1'b0;
      bus.S_ADDR   <= '0;
      bus.S_WD     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            state      <= ISSUE;
            bus.S_SEL  <= hit_sel;
            bus.S_ADDR <= bus.RBCP_ADDR[15:0];
            bus.S_WE   <= bus.RBCP_WE;
            bus.S_RE   <= ~bus.RBCP_WE;
            bus.S_WD   <= bus.RBCP_WD;
            wait_cnt   <= '0;
          end
        end
        ISSUE, WAIT: begin
          if (!bus.RBCP_ACT || ack_sel || timed_out) begin
            bus.S_SEL <= '0;
            bus.S_WE  <= 1'b0;
            bus.S_RE  <= 1'b0;
          end
          // Session abort outranks a simultaneous ack; an ack outranks the timeout.
          if (!bus.RBCP_ACT) begin
            state <= IDLE;
          end else if (ack_sel) begin
            state        <= DONE;
            bus.RBCP_ACK <= 1'b1;
            bus.RBCP_RD  <= bus.S_WE ? 8'h00 : sel_rd;
          end else if (state == ISSUE) begin
            state <= WAIT;
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.RBCP_ACK <= 1'b0;
          bus.RBCP_RD  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_TIMEOUT  <= '0;
      CNT_UNMAPPED <= '0;
    end else begin
      if (CNT_CLR)                                 CNT_TIMEOUT <= '0;
      else if (timed_out && CNT_TIMEOUT != 8'hFF)  CNT_TIMEOUT <= CNT_TIMEOUT + 8'd1;

      if (CNT_CLR)                                 CNT_UNMAPPED <= '0;
      else if (unmapped && CNT_UNMAPPED != 8'hFF)  CNT_UNMAPPED <= CNT_UNMAPPED + 8'd1;
    end
  end

endmodule

// File: tb/tb_rbcp_bus_arbiter.sv
// Bench for rbcp_bus_arbiter: decode table, directed corner sequences, and a random
// run checked every cycle against a transaction-level reference model.
module tb_rbcp_bus_arbiter;

  localparam int NS = 5;
  localparam int TO = 255;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CNT_CLR;
  logic [7:0] CNT_TIMEOUT;
  logic [7:0] CNT_UNMAPPED;
  logic       BUSY;

  rbcp_bus_arbiter_if #(.N_SLAVES(NS)) bus ();

  rbcp_bus_arbiter #(
    .N_SLAVES    (NS),
    .REGION_BASE ({16'h4, 16'h3, 16'h2, 16'h1, 16'h0}),
    .TIMEOUT     (TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .CNT_CLR      (CNT_CLR),
    .CNT_TIMEOUT  (CNT_TIMEOUT),
    .CNT_UNMAPPED (CNT_UNMAPPED),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_txn;      // a slave is currently strobed
  int         m_slave;
  bit         m_write;
  logic [15:0] m_addr;
  logic [7:0] m_wd;
  int         m_age;      // strobe cycles elapsed, 1 = first cycle
  bit         m_done;     // RBCP_ACK cycle
  logic [7:0] m_rd;
  int         m_cto;
  int         m_cum;

  function automatic int region_of(input logic [31:0] a);
    return (a[31:16] < NS) ? int'(a[31:16]) : -1;
  endfunction

  task automatic model_reset();
    m_txn = 0; m_done = 0; m_rd = 0; m_cto = 0; m_cum = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit inc_to;
    bit inc_um;
    int r;
    inc_to = 0;
    inc_um = 0;
    if (RST) begin
      model_reset();
      return;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_txn) begin
      if (!bus.RBCP_ACT) begin
        m_txn = 0;
      end else if (bus.S_ACK[m_slave]) begin
        m_txn  = 0;
        m_done = 1;
        m_rd   = m_write ? 8'h00 : bus.S_RD[m_slave*8 +: 8];
      end else if (m_age == TO + 1) begin
        m_txn  = 0;
        inc_to = 1;
      end else begin
        m_age++;
      end
    end else if (bus.RBCP_WE || bus.RBCP_RE) begin
      r = region_of(bus.RBCP_ADDR);
      if (r < 0) inc_um = 1;
      else begin
        m_txn   = 1;
        m_slave = r;
        m_write = bus.RBCP_WE;
        m_addr  = bus.RBCP_ADDR[15:0];
        m_wd    = bus.RBCP_WD;
        m_age   = 1;
      end
    end
    if (CNT_CLR) m_cto = 0; else if (inc_to && m_cto < 255) m_cto++;
    if (CNT_CLR) m_cum = 0; else if (inc_um && m_cum < 255) m_cum++;
  endtask

  task automatic compare_all();
    logic [NS-1:0] exp_sel;
    exp_sel = '0;
    if (m_txn) exp_sel[m_slave] = 1'b1;
    check("m_s_sel", bus.S_SEL, exp_sel);
    if (m_txn) begin
      check("m_s_type", {bus.S_WE, bus.S_RE}, {m_write, !m_write});
      check("m_s_addr", bus.S_ADDR, m_addr);
      if (m_write) check("m_s_wd", bus.S_WD, m_wd);
    end
    check("m_rbcp", {bus.RBCP_ACK, bus.RBCP_RD}, {m_done, (m_done ? m_rd : 8'h00)});
    check("m_busy", BUSY, m_txn || m_done);
    check("m_cnt", {CNT_TIMEOUT, CNT_UNMAPPED}, {m_cto[7:0], m_cum[7:0]});
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs are read 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic req(input logic [31:0] addr, input logic we, input logic re, input logic [7:0] wd);
    bus.RBCP_ADDR = addr;
    bus.RBCP_WE   = we;
    bus.RBCP_RE   = re;
    bus.RBCP_WD   = wd;
    tick();
    bus.RBCP_WE = 1'b0;
    bus.RBCP_RE = 1'b0;
  endtask

  typedef struct {
    logic [31:0]   addr;
    logic          we;
    logic          re;
    logic [7:0]    wd;
    logic [7:0]    srd;
    logic [NS-1:0] exp_sel;
    logic          exp_we;
    logic [7:0]    exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_um;
    int sel_cycles;
    int acks;
    bit saw_ack;
    logic [63:0] r64;

    vecs[0] = '{32'h0000_0001, 1'b1, 1'b0, 8'h3C, 8'h00, 5'b00001, 1'b1, 8'h00};
    vecs[1] = '{32'h0001_00FF, 1'b0, 1'b1, 8'h00, 8'h11, 5'b00010, 1'b0, 8'h11};
    vecs[2] = '{32'h0002_0010, 1'b0, 1'b1, 8'h00, 8'hA5, 5'b00100, 1'b0, 8'hA5};
    vecs[3] = '{32'h0003_ABCD, 1'b1, 1'b1, 8'h5A, 8'h77, 5'b01000, 1'b1, 8'h00};
    vecs[4] = '{32'h0004_FFFF, 1'b0, 1'b1, 8'h00, 8'hC3, 5'b10000, 1'b0, 8'hC3};
    vecs[5] = '{32'h0009_0000, 1'b0, 1'b1, 8'h00, 8'h00, 5'b00000, 1'b0, 8'h00};
    vecs[6] = '{32'hFFFF_0004, 1'b1, 1'b0, 8'h12, 8'h00, 5'b00000, 1'b0, 8'h00};

    bus.RBCP_ACT  = 1'b1;
    bus.RBCP_WE   = 1'b0;
    bus.RBCP_RE   = 1'b0;
    bus.RBCP_ADDR = '0;
    bus.RBCP_WD   = '0;
    bus.S_RD      = '0;
    bus.S_ACK     = '0;
    CNT_CLR       = 1'b0;
    RST           = 1'b1;
    model_reset();

    // Reset state
    tick();
    tick();
    check("rst_s_sel", bus.S_SEL, 0);
    check("rst_s_type", {bus.S_WE, bus.S_RE}, 0);
    check("rst_s_addr_wd", {bus.S_ADDR, bus.S_WD}, 0);
    check("rst_rbcp", {bus.RBCP_ACK, bus.RBCP_RD}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_cnt", {CNT_TIMEOUT, CNT_UNMAPPED}, 0);
    RST = 1'b0;
    tick();

    // Decode table: each hit acked during ISSUE, so RBCP_ACK follows two cycles after the request
    exp_um = 0;
    for (int v = 0; v < 7; v++) begin
      req(vecs[v].addr, vecs[v].we, vecs[v].re, vecs[v].wd);
      check("vec_sel", bus.S_SEL, vecs[v].exp_sel);
      if (vecs[v].exp_sel != 0) begin
        check("vec_type", {bus.S_WE, bus.S_RE}, {vecs[v].exp_we, !vecs[v].exp_we});
        check("vec_addr", bus.S_ADDR, vecs[v].addr[15:0]);
        if (vecs[v].exp_we) check("vec_wd", bus.S_WD, vecs[v].wd);
        bus.S_RD = {NS{~vecs[v].srd}};
        for (int i = 0; i < NS; i++) if (vecs[v].exp_sel[i]) bus.S_RD[i*8 +: 8] = vecs[v].srd;
        bus.S_ACK = vecs[v].exp_sel;
        tick();
        bus.S_ACK = '0;
        check("vec_ack", {bus.RBCP_ACK, bus.RBCP_RD}, {1'b1, vecs[v].exp_rd});
        tick();
        check("vec_ack_end", {bus.RBCP_ACK, bus.RBCP_RD}, 0);
      end else begin
        exp_um++;
        check("vec_unmapped", CNT_UNMAPPED, exp_um);
        check("vec_miss_busy", BUSY, 0);
        tick();
      end
    end

    // Read 0x0002_0010, slave 2 acks in the fourth strobe cycle with 0xA5
    req(32'h0002_0010, 1'b0, 1'b1, 8'h00);
    check("rd_a5_issue", {bus.S_SEL, bus.S_RE, bus.S_ADDR}, {5'b00100, 1'b1, 16'h0010});
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rd_a5_hold", {bus.S_SEL, bus.RBCP_ACK}, {5'b00100, 1'b0});
    end
    bus.S_RD = '0;
    bus.S_RD[23:16] = 8'hA5;
    bus.S_ACK[2] = 1'b1;
    tick();
    bus.S_ACK = '0;
    check("rd_a5_ack", {bus.S_SEL, bus.RBCP_ACK, bus.RBCP_RD}, {5'b00000, 1'b1, 8'hA5});
    tick();
    check("rd_a5_single", {bus.RBCP_ACK, bus.RBCP_RD}, 0);

    // Unmapped counter: first increment, saturation, clear-over-increment
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check("um_clear", CNT_UNMAPPED, 0);
    for (int n = 0; n < 300; n++) begin
      req(32'h0009_0000, 1'b0, 1'b1, 8'h00);
      if (n == 0) check("um_first", {CNT_UNMAPPED, bus.RBCP_ACK, bus.S_SEL}, {8'h01, 1'b0, 5'b0});
      tick();
    end
    check("um_saturate", CNT_UNMAPPED, 8'hFF);
    CNT_CLR = 1'b1;
    req(32'h0009_0000, 1'b0, 1'b1, 8'h00);
    CNT_CLR = 1'b0;
    check("um_clr_priority", CNT_UNMAPPED, 0);

    // Slave 4 never acks: strobe for TIMEOUT+1 cycles, then back to idle
    req(32'h0004_0000, 1'b0, 1'b1, 8'h00);
    sel_cycles = 0;
    saw_ack = 0;
    for (int c = 0; c < 400 && bus.S_SEL[4]; c++) begin
      sel_cycles++;
      if (bus.RBCP_ACK) saw_ack = 1;
      tick();
    end
    check("to_sel_cycles", sel_cycles, 256);
    check("to_no_ack", {saw_ack, bus.RBCP_ACK}, 0);
    check("to_count", CNT_TIMEOUT, 1);
    check("to_busy", BUSY, 0);

    // Ack arriving in the final strobe cycle beats the timeout
    req(32'h0003_0000, 1'b0, 1'b1, 8'h00);
    for (int c = 0; c < 255; c++) tick();
    check("to_race_sel", bus.S_SEL, 5'b01000);
    bus.S_RD = '0;
    bus.S_RD[31:24] = 8'h6E;
    bus.S_ACK[3] = 1'b1;
    tick();
    bus.S_ACK = '0;
    check("to_race_ack", {bus.RBCP_ACK, bus.RBCP_RD, CNT_TIMEOUT}, {1'b1, 8'h6E, 8'h01});
    tick();

    // Session abort in WAIT, late ack ignored, next read completes
    req(32'h0001_0000, 1'b0, 1'b1, 8'h00);
    tick();
    bus.RBCP_ACT = 1'b0;
    tick();
    check("abort_idle", {bus.S_SEL, BUSY, bus.RBCP_ACK}, 0);
    bus.RBCP_ACT = 1'b1;
    bus.S_ACK = 5'b00010;
    tick();
    check("abort_late_ack0", bus.RBCP_ACK, 0);
    tick();
    check("abort_late_ack1", bus.RBCP_ACK, 0);
    bus.S_ACK = '0;
    check("abort_cnt", {CNT_TIMEOUT, CNT_UNMAPPED}, {8'h01, 8'h00});
    req(32'h0001_0020, 1'b0, 1'b1, 8'h00);
    bus.S_RD[15:8] = 8'h42;
    bus.S_ACK[1] = 1'b1;
    tick();
    bus.S_ACK = '0;
    check("abort_next_rd", {bus.RBCP_ACK, bus.RBCP_RD}, {1'b1, 8'h42});
    tick();

    // WE and RE together is a write; a request during WAIT is dropped
    acks = 0;
    req(32'h0002_0005, 1'b1, 1'b1, 8'h99);
    acks += int'(bus.RBCP_ACK);
    check("both_write", {bus.S_SEL, bus.S_WE, bus.S_RE, bus.S_WD}, {5'b00100, 1'b1, 1'b0, 8'h99});
    tick();
    acks += int'(bus.RBCP_ACK);
    req(32'h0001_0000, 1'b0, 1'b1, 8'h00);
    acks += int'(bus.RBCP_ACK);
    check("both_drop_sel", bus.S_SEL, 5'b00100);
    bus.S_RD[23:16] = 8'hFF;
    bus.S_ACK[2] = 1'b1;
    tick();
    bus.S_ACK = '0;
    acks += int'(bus.RBCP_ACK);
    check("both_ack_rd", {bus.RBCP_ACK, bus.RBCP_RD}, {1'b1, 8'h00});
    for (int c = 0; c < 5; c++) begin
      tick();
      acks += int'(bus.RBCP_ACK);
      check("both_no_second", bus.S_SEL, 0);
    end
    check("both_one_ack", acks, 1);

    // Acks from non-selected slaves are ignored
    req(32'h0000_0000, 1'b0, 1'b1, 8'h00);
    bus.S_ACK = 5'b11110;
    tick();
    check("nonsel_ignored", {bus.S_SEL, bus.RBCP_ACK}, {5'b00001, 1'b0});
    bus.S_ACK = 5'b00001;
    bus.S_RD[7:0] = 8'h5A;
    tick();
    bus.S_ACK = '0;
    check("nonsel_own_ack", {bus.RBCP_ACK, bus.RBCP_RD}, {1'b1, 8'h5A});
    tick();

    // Reset mid-transaction abandons it
    req(32'h0003_0000, 1'b0, 1'b1, 8'h00);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_state", {bus.S_SEL, BUSY, CNT_TIMEOUT}, 0);
    bus.S_ACK[3] = 1'b1;
    tick();
    check("midrst_ack0", bus.RBCP_ACK, 0);
    tick();
    check("midrst_ack1", bus.RBCP_ACK, 0);
    bus.S_ACK = '0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.RBCP_ACT = ($urandom % 20) != 0;
      if ($urandom % 3 == 0) begin
        bus.RBCP_WE = $urandom % 2 == 0;
        bus.RBCP_RE = !bus.RBCP_WE || ($urandom % 2 == 0);
      end else begin
        bus.RBCP_WE = 1'b0;
        bus.RBCP_RE = 1'b0;
      end
      bus.RBCP_ADDR = {16'($urandom % 7), 16'($urandom)};
      bus.RBCP_WD   = 8'($urandom);
      for (int i = 0; i < NS; i++) bus.S_ACK[i] = ($urandom % 3) == 0;
      r64 = {$urandom, $urandom};
      bus.S_RD = r64[NS*8-1:0];
      CNT_CLR = ($urandom % 50) == 0;
      RST     = ($urandom % 400) == 0;
      tick();
    end
    RST = 1'b0;
    CNT_CLR = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rbcp_bus_arbiter.md
RBCP_BUS_ARBITER -- requirements
Module: rbcp_bus_arbiter

Interface
REQ-001 Parameter N_SLAVES, default 5, gives the number of slave regions (1..16).
REQ-002 Parameter REGION_BASE, default {16'h4,16'h3,16'h2,16'h1,16'h0}, is packed N_SLAVES*16 bits; slave i owns RBCP_ADDR[31:16]==REGION_BASE[i*16+:16].
REQ-003 Parameter TIMEOUT, default 255, is the slave-response wait limit in cycles (1..65535).
REQ-004 CLK  in  1  the single clock; all logic is synchronous to its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 RBCP_ACT  in  1  RBCP session active.
REQ-007 RBCP_ADDR  in  32  RBCP address.
REQ-008 RBCP_WE / RBCP_RE  in  1 each  single-cycle write / read strobes.
REQ-009 RBCP_WD  in  8  write data.
REQ-010 RBCP_RD  out  8  read data, valid only with RBCP_ACK.
REQ-011 RBCP_ACK  out  1  single-cycle acknowledge.
REQ-012 S_SEL  out  N_SLAVES  one-hot slave strobe.
REQ-013 S_ADDR  out  16  sub-address RBCP_ADDR[15:0], registered.
REQ-014 S_WE / S_RE  out  1 each  access type, valid with S_SEL.
REQ-015 S_WD  out  8  write data, valid with S_SEL.
REQ-016 S_RD  in  N_SLAVES*8  per-slave read data, byte i = slave i.
REQ-017 S_ACK  in  N_SLAVES  per-slave acknowledge.
REQ-018 CNT_CLR  in  1  clears both error counters.
REQ-019 CNT_TIMEOUT / CNT_UNMAPPED  out  8 each  saturating error counters.
REQ-020 BUSY  out  1  high whenever the FSM is not IDLE.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: a request is RBCP_WE|RBCP_RE sampled high; address, data and type are captured on that edge.
REQ-023 If WE and RE are both high, the access is a write.
REQ-024 Decode: the lowest index i whose REGION_BASE matches wins; a hit moves IDLE->ISSUE.
REQ-025 A miss stays in IDLE, gives no RBCP_ACK, and increments CNT_UNMAPPED.
REQ-026 ISSUE lasts exactly one cycle with S_SEL[i]=1 and S_WE/S_RE, S_ADDR and S_WD valid; it then moves to WAIT, or directly to DONE if S_ACK[i] is sampled high during ISSUE.
REQ-027 S_SEL stays high through WAIT (Wishbone-style hold) and drops on the cycle after S_ACK[i] is sampled.
REQ-028 WAIT: on S_ACK[i], latch S_RD[i*8+:8] for reads (0 for writes) and move to DONE.
REQ-029 S_ACK bits of non-selected slaves are ignored in every state.
REQ-030 Wait counter: cleared on ISSUE entry, incremented each WAIT cycle.
REQ-031 When the counter reaches TIMEOUT without S_ACK[i], the FSM moves WAIT->IDLE, drops S_SEL, gives no RBCP_ACK, and increments CNT_TIMEOUT.
REQ-032 If S_ACK[i] arrives on the same cycle as the timeout, the ACK wins.
REQ-033 DONE lasts one cycle with RBCP_ACK=1 and RBCP_RD=latched byte, then moves to IDLE.
REQ-034 Latency: request sampled at edge t -> S_SEL high in cycle t+1; S_ACK sampled at edge t+1+k -> RBCP_ACK high in cycle t+2+k.
REQ-035 RBCP_RD is 0 in every cycle where RBCP_ACK is 0.
REQ-036 Requests arriving while not in IDLE are discarded and not queued.
REQ-037 RBCP_ACT low during ISSUE or WAIT aborts to IDLE: S_SEL drops, no RBCP_ACK, no counter change.
REQ-038 Counters saturate at 8'hFF.
REQ-039 CNT_CLR has priority over a simultaneous increment; the counter result is 0.

Reset
REQ-040 RST forces state=IDLE, RBCP_ACK=0, RBCP_RD=0, S_SEL=0, S_WE=0, S_RE=0, S_ADDR=0, S_WD=0, wait counter=0, CNT_TIMEOUT=0, CNT_UNMAPPED=0, BUSY=0.
REQ-041 RST asserted mid-transaction abandons the transaction; a later S_ACK produces no RBCP_ACK.

Verification
REQ-042 Read from 0x0002_0010, slave 2 acks 3 cycles after S_SEL with 8'hA5 -> S_ADDR=16'h0010, S_RE=1, then a single RBCP_ACK with RBCP_RD=8'hA5 one cycle after the ack.
REQ-043 Write 8'h3C to 0x0000_0001, slave 0 acks in the ISSUE cycle -> S_WD=8'h3C, S_WE=1, RBCP_ACK in cycle t+2, RBCP_RD=0.
REQ-044 Read from 0x0009_0000 -> no S_SEL, no RBCP_ACK, CNT_UNMAPPED 0->1; 300 such reads -> 8'hFF.
REQ-045 Read from slave 4, which never acks, TIMEOUT=255 -> S_SEL high for 256 cycles, no RBCP_ACK, CNT_TIMEOUT=1, BUSY=0 afterwards.
REQ-046 RBCP_ACT deasserted in WAIT, then a late S_ACK -> no RBCP_ACK; the next read to slave 1 completes normally.
REQ-047 WE and RE high together, plus a second request during WAIT -> treated as one write only, the second request is dropped, exactly one RBCP_ACK.
